// File: rtl/regs_wr_arbiter_if.sv
// regs_wr_arbiter_if: requester handshakes plus register-file write port for regs_wr_arbiter.
// Forwarding signals exist only when REGS_WR_ARBITER_BYPASS_EN is defined.
interface regs_wr_arbiter_if #(parameter int DATA_WIDTH = 32, parameter int INDEX_WIDTH = 5);
  logic                   i_a_valid;
  logic [INDEX_WIDTH-1:0] i_a_index;
  logic [DATA_WIDTH-1:0]  i_a_data;
  logic                   o_a_ready;
  logic                   i_b_valid;
  logic [INDEX_WIDTH-1:0] i_b_index;
  logic [DATA_WIDTH-1:0]  i_b_data;
  logic                   o_b_ready;
  logic [INDEX_WIDTH-1:0] o_wr_index;
  logic [DATA_WIDTH-1:0]  o_wr_data;
  logic                   o_wr_enable;
  logic                   o_conflict;
`ifdef REGS_WR_ARBITER_BYPASS_EN
  logic [INDEX_WIDTH-1:0] i_rd_index1;
  logic [INDEX_WIDTH-1:0] i_rd_index2;
  logic                   o_byp_hit1;
  logic                   o_byp_hit2;
  logic [DATA_WIDTH-1:0]  o_byp_data1;
  logic [DATA_WIDTH-1:0]  o_byp_data2;
  modport slave (
    input  i_a_valid, i_a_index, i_a_data, i_b_valid, i_b_index, i_b_data, i_rd_index1, i_rd_index2,
    output o_a_ready, o_b_ready, o_wr_index, o_wr_data, o_wr_enable, o_conflict,
           o_byp_hit1, o_byp_hit2, o_byp_data1, o_byp_data2
  );
  modport master (
    output i_a_valid, i_a_index, i_a_data, i_b_valid, i_b_index, i_b_data, i_rd_index1, i_rd_index2,
    input  o_a_ready, o_b_ready, o_wr_index, o_wr_data, o_wr_enable, o_conflict,
           o_byp_hit1, o_byp_hit2, o_byp_data1, o_byp_data2
  );
`else
  modport slave (
    input  i_a_valid, i_a_index, i_a_data, i_b_valid, i_b_index, i_b_data,
    output o_a_ready, o_b_ready, o_wr_index, o_wr_data, o_wr_enable, o_conflict
  );
  modport master (
    output i_a_valid, i_a_index, i_a_data, i_b_valid, i_b_index, i_b_data,
    input  o_a_ready, o_b_ready, o_wr_index, o_wr_data, o_wr_enable, o_conflict
  );
`endif
endinterface

// File: rtl/regs_wr_arbiter.sv
// regs_wr_arbiter: round-robin share of the register-file write port between requesters A and B.
// Define REGS_WR_ARBITER_BYPASS_EN to add forwarding of the uncommitted write to two read indices.
module regs_wr_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 5
) (
  input logic            i_clk,
  input logic            i_rst,
  regs_wr_arbiter_if.slave bus
);
  logic                   r_rr;
  logic                   r_wr_enable;
  logic                   r_conflict;
  logic [INDEX_WIDTH-1:0] r_wr_index;
  logic [DATA_WIDTH-1:0]  r_wr_data;
  logic                   w_both;
  logic                   w_a_ready;
  logic                   w_b_ready;
  logic                   w_xfer;
  logic [INDEX_WIDTH-1:0] w_index;
  logic [DATA_WIDTH-1:0]  w_data;
  // r_rr=0 means A wins the next conflict; readies are forced low while in reset
  always_comb begin
    w_both    = bus.i_a_valid & bus.i_b_valid;
    w_a_ready = i_rst & bus.i_a_valid & (~bus.i_b_valid | ~r_rr);
    w_b_ready = i_rst & bus.i_b_valid & (~bus.i_a_valid | r_rr);
    w_xfer    = w_a_ready | w_b_ready;
    w_index   = w_a_ready ? bus.i_a_index : bus.i_b_index;
    w_data    = w_a_ready ? bus.i_a_data : bus.i_b_data;
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rr        <= 1'b0;
      r_wr_enable <= 1'b0;
      r_conflict  <= 1'b0;
      r_wr_index  <= '0;
      r_wr_data   <= '0;
    end else begin
      r_wr_enable <= w_xfer && (w_index != '0);
      r_conflict  <= w_both;
      if (w_both) r_rr <= ~r_rr;
      if (w_xfer) begin
        r_wr_index <= w_index;
        r_wr_data  <= w_data;
      end
    end
  end
  assign bus.o_a_ready   = w_a_ready;
  assign bus.o_b_ready   = w_b_ready;
  assign bus.o_wr_index  = r_wr_index;
  assign bus.o_wr_data   = r_wr_data;
  assign bus.o_wr_enable = r_wr_enable;
  assign bus.o_conflict  = r_conflict;
`ifdef REGS_WR_ARBITER_BYPASS_EN
  // enable is never set for index 0, so x0 cannot hit
  logic w_hit1, w_hit2;
  assign w_hit1          = r_wr_enable && (r_wr_index == bus.i_rd_index1);
  assign w_hit2          = r_wr_enable && (r_wr_index == bus.i_rd_index2);
  assign bus.o_byp_hit1  = w_hit1;
  assign bus.o_byp_hit2  = w_hit2;
  assign bus.o_byp_data1 = w_hit1 ? r_wr_data : '0;
  assign bus.o_byp_data2 = w_hit2 ? r_wr_data : '0;
`endif
endmodule

// File: tb/tb_regs_wr_arbiter.sv
// tb_regs_wr_arbiter: directed stimulus checked every cycle against a behavioural model,
// plus literal expectations on the observed grant order and write stream.
module tb_regs_wr_arbiter;
  localparam int DW = 32;
  localparam int IW = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;
  int n_conf = 0;
  typedef struct { logic [IW-1:0] idx; logic [DW-1:0] data; int cyc; } wr_t;
  wr_t  writes[$];
  byte  grants[$];
  logic          m_turn_b;
  logic          m_en, m_conf;
  logic [IW-1:0] m_idx;
  logic [DW-1:0] m_data;
  logic          ea, eb;

  regs_wr_arbiter_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) bif ();
  regs_wr_arbiter #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (.i_clk(clk), .i_rst(rst_n), .bus(bif));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: a conflict goes to whichever side's turn it is and then hands the turn over;
  // the accepted write shows up on the port one edge later, suppressed for x0.
  always @(negedge clk) begin
    cyc_n++;
    if (!rst_n) begin
      chk("rst_a_ready", bif.o_a_ready, 0);
      chk("rst_b_ready", bif.o_b_ready, 0);
      chk("rst_wr_enable", bif.o_wr_enable, 0);
      chk("rst_wr_index", bif.o_wr_index, 0);
      chk("rst_wr_data", bif.o_wr_data, 0);
      chk("rst_conflict", bif.o_conflict, 0);
      m_turn_b = 0; m_en = 0; m_conf = 0; m_idx = 0; m_data = 0;
    end else begin
      if (bif.i_a_valid && bif.i_b_valid) begin
        ea = !m_turn_b; eb = m_turn_b;
      end else begin
        ea = bif.i_a_valid; eb = bif.i_b_valid;
      end
      chk("a_ready", bif.o_a_ready, ea);
      chk("b_ready", bif.o_b_ready, eb);
      chk("wr_enable", bif.o_wr_enable, m_en);
      chk("wr_index", bif.o_wr_index, m_idx);
      chk("wr_data", bif.o_wr_data, m_data);
      chk("conflict", bif.o_conflict, m_conf);
`ifdef REGS_WR_ARBITER_BYPASS_EN
      chk("byp_hit1", bif.o_byp_hit1, m_en && m_idx == bif.i_rd_index1);
      chk("byp_hit2", bif.o_byp_hit2, m_en && m_idx == bif.i_rd_index2);
      chk("byp_data1", bif.o_byp_data1, (m_en && m_idx == bif.i_rd_index1) ? m_data : 0);
      chk("byp_data2", bif.o_byp_data2, (m_en && m_idx == bif.i_rd_index2) ? m_data : 0);
`endif
      if (bif.o_a_ready) grants.push_back("A");
      if (bif.o_b_ready) grants.push_back("B");
      if (bif.o_wr_enable) writes.push_back('{bif.o_wr_index, bif.o_wr_data, cyc_n});
      if (bif.o_conflict) n_conf++;
      m_conf = bif.i_a_valid && bif.i_b_valid;
      if (m_conf) m_turn_b = !m_turn_b;
      if (ea || eb) begin
        m_idx  = ea ? bif.i_a_index : bif.i_b_index;
        m_data = ea ? bif.i_a_data : bif.i_b_data;
        m_en   = m_idx != 0;
      end else m_en = 0;
    end
  end

  task automatic clear_logs();
    writes.delete(); grants.delete(); n_conf = 0;
  endtask

  task automatic set_a(input logic v, input logic [IW-1:0] i, input logic [DW-1:0] d);
    bif.i_a_valid = v; bif.i_a_index = i; bif.i_a_data = d;
  endtask

  task automatic set_b(input logic v, input logic [IW-1:0] i, input logic [DW-1:0] d);
    bif.i_b_valid = v; bif.i_b_index = i; bif.i_b_data = d;
  endtask

  initial begin
`ifdef REGS_WR_ARBITER_BYPASS_EN
    bif.i_rd_index1 = 0; bif.i_rd_index2 = 0;
`endif
    // reset held with both requesters valid
    set_a(1, 1, 32'hA1); set_b(1, 2, 32'hB2);
    repeat (3) cyc();
    rst_n = 1;
    cyc();
    set_a(0, 0, 0);
    cyc();
    set_b(0, 0, 0);
    repeat (2) cyc();
    chk("first_grant_after_reset", grants.size() > 0 ? grants[0] : 0, "A");
    chk("second_grant", grants.size() > 1 ? grants[1] : 0, "B");
    chk("init_writes", writes.size(), 2);
    clear_logs();
    // single A write
    set_a(1, 5, 32'hDEADBEEF);
    cyc();
    set_a(0, 0, 0);
    cyc();
    cyc();
    chk("single_count", writes.size(), 1);
    chk("single_idx", writes.size() > 0 ? writes[0].idx : 0, 5);
    chk("single_data", writes.size() > 0 ? writes[0].data : 0, 32'hDEADBEEF);
    // reset while a write sits in the output stage
    set_a(1, 6, 32'h66);
    cyc();
    set_a(0, 0, 0);
    chk("pre_reset_enable", bif.o_wr_enable, 1);
    rst_n = 0;
    #1;
    chk("async_enable_drop", bif.o_wr_enable, 0);
    chk("async_index_clear", bif.o_wr_index, 0);
    cyc();
    rst_n = 1;
    cyc();
    clear_logs();
    // continuous conflict, loser holds its data, winner presents new data
    set_a(1, 3, 32'h11); set_b(1, 4, 32'h22); cyc();
    set_a(1, 3, 32'h13); cyc();
    set_b(1, 4, 32'h24); cyc();
    set_a(1, 3, 32'h15); cyc();
    set_a(0, 0, 0); set_b(0, 0, 0);
    cyc();
    cyc();
    chk("conflict_grants", grants.size() == 4 ? {grants[0], grants[1], grants[2], grants[3]} : 0, "ABAB");
    chk("conflict_pulses", n_conf, 4);
    chk("conflict_writes", writes.size(), 4);
    if (writes.size() == 4) begin
      chk("cw0", {writes[0].idx, writes[0].data}, {5'd3, 32'h11});
      chk("cw1", {writes[1].idx, writes[1].data}, {5'd4, 32'h22});
      chk("cw2", {writes[2].idx, writes[2].data}, {5'd3, 32'h13});
      chk("cw3", {writes[3].idx, writes[3].data}, {5'd4, 32'h24});
    end
    clear_logs();
    // x0 write is accepted but never enabled
    set_b(1, 0, 32'hFFFFFFFF);
    cyc();
    set_b(0, 0, 0);
    repeat (2) cyc();
    chk("x0_grant", grants.size() == 1 ? grants[0] : 0, "B");
    chk("x0_no_write", writes.size(), 0);
    clear_logs();
    // same index from both, A's turn
    set_a(1, 7, 32'hAAAA); set_b(1, 7, 32'hBBBB);
    cyc();
    set_a(0, 0, 0);
    cyc();
    set_b(0, 0, 0);
    repeat (2) cyc();
    chk("same_count", writes.size(), 2);
    if (writes.size() == 2) begin
      chk("same_first", {writes[0].idx, writes[0].data}, {5'd7, 32'hAAAA});
      chk("same_second", {writes[1].idx, writes[1].data}, {5'd7, 32'hBBBB});
      chk("same_consecutive", writes[1].cyc - writes[0].cyc, 1);
    end
`ifdef REGS_WR_ARBITER_BYPASS_EN
    set_a(1, 9, 32'h1234);
    cyc();
    set_a(0, 0, 0);
    bif.i_rd_index1 = 9; bif.i_rd_index2 = 0;
    #1;
    chk("byp_lit_hit1", bif.o_byp_hit1, 1);
    chk("byp_lit_data1", bif.o_byp_data1, 32'h1234);
    chk("byp_lit_hit2", bif.o_byp_hit2, 0);
    chk("byp_lit_data2", bif.o_byp_data2, 0);
    cyc();
    cyc();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
